// File: rtl/traffic_ctrl.sv
// Two-road traffic light phase sequencer with countdown outputs, freeze and night flashing mode.
// All outputs decode from registered state only.
module traffic_ctrl #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned GREEN_T  = 27,
    parameter int unsigned YELLOW_T = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       run,
    input  logic       night,
    output logic [5:0] ew_time,
    output logic [5:0] sn_time,
    output logic       en,
    output logic [2:0] ew_led,
    output logic [2:0] sn_led
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TickMax = TW'(TICK_DIV - 1);
    localparam logic [5:0] GreenT  = 6'(GREEN_T);
    localparam logic [5:0] YellowT = 6'(YELLOW_T);

    typedef enum logic [2:0] {
        StEwGreen,
        StEwYellow,
        StSnGreen,
        StSnYellow,
        StFlash
    } state_e;

    state_e        state_q;
    logic [TW-1:0] tick_cnt_q;
    logic [5:0]    phase_cnt_q;
    logic          flash_q;
    logic          tick;

    assign tick = run && (tick_cnt_q == TickMax);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= StEwGreen;
            phase_cnt_q <= GreenT;
            tick_cnt_q  <= '0;
            flash_q     <= 1'b0;
        end else if (night && (state_q != StFlash)) begin
            // Night entry wins over any coincident tick.
            state_q    <= StFlash;
            flash_q    <= 1'b1;
            tick_cnt_q <= '0;
        end else if (!night && (state_q == StFlash)) begin
            state_q     <= StEwGreen;
            phase_cnt_q <= GreenT;
            tick_cnt_q  <= '0;
            flash_q     <= 1'b0;
        end else begin
            if (run) begin
                tick_cnt_q <= (tick_cnt_q == TickMax) ? '0 : tick_cnt_q + 1'b1;
            end
            if (tick) begin
                if (state_q == StFlash) begin
                    flash_q <= ~flash_q;
                end else if (phase_cnt_q == 6'd1) begin
                    unique case (state_q)
                        StEwGreen: begin
                            state_q     <= StEwYellow;
                            phase_cnt_q <= YellowT;
                        end
                        StEwYellow: begin
                            state_q     <= StSnGreen;
                            phase_cnt_q <= GreenT;
                        end
                        StSnGreen: begin
                            state_q     <= StSnYellow;
                            phase_cnt_q <= YellowT;
                        end
                        StSnYellow: begin
                            state_q     <= StEwGreen;
                            phase_cnt_q <= GreenT;
                        end
                        default: begin
                            state_q     <= StEwGreen;
                            phase_cnt_q <= GreenT;
                        end
                    endcase
                end else begin
                    phase_cnt_q <= phase_cnt_q - 6'd1;
                end
            end
        end
    end

    always_comb begin
        ew_time = 6'd0;
        sn_time = 6'd0;
        en      = 1'b1;
        ew_led  = 3'b100;
        sn_led  = 3'b100;
        unique case (state_q)
            StEwGreen: begin
                ew_led  = 3'b001;
                ew_time = phase_cnt_q;
                sn_time = phase_cnt_q + YellowT;
            end
            StEwYellow: begin
                ew_led  = 3'b010;
                ew_time = phase_cnt_q;
                sn_time = phase_cnt_q;
            end
            StSnGreen: begin
                sn_led  = 3'b001;
                ew_time = phase_cnt_q + YellowT;
                sn_time = phase_cnt_q;
            end
            StSnYellow: begin
                sn_led  = 3'b010;
                ew_time = phase_cnt_q;
                sn_time = phase_cnt_q;
            end
            default: begin
                en     = 1'b0;
                ew_led = {1'b0, flash_q, 1'b0};
                sn_led = {1'b0, flash_q, 1'b0};
            end
        endcase
    end

endmodule
